// File: rtl/memory_stage_pkg.sv
// Shared memory-instruction definitions for the decoder, M stage and W stage.
package memory_stage_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_W    = 3'd1,
    LD_H    = 3'd2,
    LD_HU   = 3'd3,
    LD_B    = 3'd4,
    LD_BU   = 3'd5
  } ld_kind_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_W    = 2'd1,
    ST_H    = 2'd2,
    ST_B    = 2'd3
  } st_kind_e;

  // Map an opcode to its load kind; anything else is not a load.
  function automatic ld_kind_e decode_ld(input logic [5:0] op);
    case (op)
      OP_LW:   return LD_W;
      OP_LH:   return LD_H;
      OP_LHU:  return LD_HU;
      OP_LB:   return LD_B;
      OP_LBU:  return LD_BU;
      default: return LD_NONE;
    endcase
  endfunction

  // Map an opcode to its store kind; anything else is not a store.
  function automatic st_kind_e decode_st(input logic [5:0] op);
    case (op)
      OP_SW:   return ST_W;
      OP_SH:   return ST_H;
      OP_SB:   return ST_B;
      default: return ST_NONE;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_data_mem.sv
// Word-organised data memory: byte-enable synchronous write, combinational read.
// Contents are deliberately not reset.
module data_mem #(
  parameter int DM_WORDS = 3072,
  localparam int AW = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1
) (
  input  logic          clk,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DM_WORDS];

  // Commit each enabled byte lane on the rising edge.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/memory_stage.sv
// MIPS memory stage: load/store lane handling, address checking and the M/W register.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_ins,
  input  logic [31:0] M_alu_res,
  input  logic [31:0] M_rt,
  input  logic        fwd_rt_W,
  input  logic [31:0] W_reg_write,
  input  logic        en,
  input  logic        flush,
  output logic [31:0] W_PC,
  output logic [31:0] W_ins,
  output logic [31:0] W_alu_res,
  output logic [31:0] W_mem_read,
  output logic        W_addr_err
);

  localparam int AW = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;

  ld_kind_e      ld_kind_s;
  st_kind_e      st_kind_s;
  logic [29:0]   widx_s;
  logic [1:0]    off_s;
  logic          oob_s;
  logic          err_s;
  logic [AW-1:0] dm_addr_s;
  logic [31:0]   store_data_s;
  logic [31:0]   dm_wdata_s;
  logic [3:0]    lane_be_s;
  logic [3:0]    dm_be_s;
  logic [31:0]   dm_rdata_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic [31:0]   load_data_s;

  logic [31:0] pc_d, ins_d, alu_d, rd_d;
  logic        err_d;
  logic [31:0] pc_q, ins_q, alu_q, rd_q;
  logic        err_q;

  assign widx_s = M_alu_res[31:2];
  assign off_s  = M_alu_res[1:0];

  // Decode the opcode and flag misaligned or out-of-range memory accesses.
  always_comb begin
    ld_kind_s = decode_ld(M_ins[31:26]);
    st_kind_s = decode_st(M_ins[31:26]);
    oob_s     = (widx_s >= 30'(DM_WORDS));
    err_s     = 1'b0;
    if ((ld_kind_s == LD_NONE) && (st_kind_s == ST_NONE)) begin
      err_s = 1'b0;
    end else if (oob_s) begin
      err_s = 1'b1;
    end else if ((ld_kind_s == LD_W) || (st_kind_s == ST_W)) begin
      err_s = (off_s != 2'd0);
    end else if ((ld_kind_s == LD_H) || (ld_kind_s == LD_HU) || (st_kind_s == ST_H)) begin
      err_s = off_s[0];
    end else begin
      err_s = 1'b0;
    end
    // Out-of-range indices never reach the array.
    dm_addr_s = oob_s ? {AW{1'b0}} : widx_s[AW-1:0];
  end

  // Select store data and replicate it across the byte lanes picked by the offset.
  always_comb begin
    store_data_s = fwd_rt_W ? W_reg_write : M_rt;
    lane_be_s    = 4'b0000;
    dm_wdata_s   = 32'h0000_0000;
    case (st_kind_s)
      ST_W: begin
        lane_be_s  = 4'b1111;
        dm_wdata_s = store_data_s;
      end
      ST_H: begin
        lane_be_s  = off_s[1] ? 4'b1100 : 4'b0011;
        dm_wdata_s = {2{store_data_s[15:0]}};
      end
      ST_B: begin
        lane_be_s  = 4'b0001 << off_s;
        dm_wdata_s = {4{store_data_s[7:0]}};
      end
      default: begin
        lane_be_s  = 4'b0000;
        dm_wdata_s = 32'h0000_0000;
      end
    endcase
    // No write during reset, flush, stall or on a faulting access.
    if (reset && en && !flush && !err_s) begin
      dm_be_s = lane_be_s;
    end else begin
      dm_be_s = 4'b0000;
    end
  end

  data_mem #(.DM_WORDS(DM_WORDS)) u_data_mem (
    .clk   (clk),
    .be    (dm_be_s),
    .addr  (dm_addr_s),
    .wdata (dm_wdata_s),
    .rdata (dm_rdata_s)
  );

  // Extract the addressed lane and sign- or zero-extend it.
  always_comb begin
    case (off_s)
      2'd0:    byte_s = dm_rdata_s[7:0];
      2'd1:    byte_s = dm_rdata_s[15:8];
      2'd2:    byte_s = dm_rdata_s[23:16];
      2'd3:    byte_s = dm_rdata_s[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = off_s[1] ? dm_rdata_s[31:16] : dm_rdata_s[15:0];
    if (err_s) begin
      load_data_s = 32'h0000_0000;
    end else begin
      case (ld_kind_s)
        LD_W:    load_data_s = dm_rdata_s;
        LD_H:    load_data_s = {{16{half_s[15]}}, half_s};
        LD_HU:   load_data_s = {16'h0000, half_s};
        LD_B:    load_data_s = {{24{byte_s[7]}}, byte_s};
        LD_BU:   load_data_s = {24'h00_0000, byte_s};
        default: load_data_s = 32'h0000_0000;
      endcase
    end
  end

  // Next M/W register contents: flush inserts a bubble, stall holds.
  always_comb begin
    if (flush) begin
      pc_d  = 32'h0000_0000;
      ins_d = 32'h0000_0000;
      alu_d = 32'h0000_0000;
      rd_d  = 32'h0000_0000;
      err_d = 1'b0;
    end else if (en) begin
      pc_d  = M_PC;
      ins_d = M_ins;
      alu_d = M_alu_res;
      rd_d  = load_data_s;
      err_d = err_s;
    end else begin
      pc_d  = pc_q;
      ins_d = ins_q;
      alu_d = alu_q;
      rd_d  = rd_q;
      err_d = err_q;
    end
  end

  // M/W pipeline register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= 32'h0000_0000;
      ins_q <= 32'h0000_0000;
      alu_q <= 32'h0000_0000;
      rd_q  <= 32'h0000_0000;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ins_q <= ins_d;
      alu_q <= alu_d;
      rd_q  <= rd_d;
      err_q <= err_d;
    end
  end

  assign W_PC       = pc_q;
  assign W_ins      = ins_q;
  assign W_alu_res  = alu_q;
  assign W_mem_read = rd_q;
  assign W_addr_err = err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed scoreboard bench for memory_stage.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int DMW = 3072;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] M_PC, M_ins, M_alu_res, M_rt, W_reg_write;
  logic        fwd_rt_W, en, flush;
  logic [31:0] W_PC, W_ins, W_alu_res, W_mem_read;
  logic        W_addr_err;

  memory_stage #(.DM_WORDS(DMW)) dut (
    .clk(clk), .reset(reset), .M_PC(M_PC), .M_ins(M_ins), .M_alu_res(M_alu_res),
    .M_rt(M_rt), .fwd_rt_W(fwd_rt_W), .W_reg_write(W_reg_write), .en(en),
    .flush(flush), .W_PC(W_PC), .W_ins(W_ins), .W_alu_res(W_alu_res),
    .W_mem_read(W_mem_read), .W_addr_err(W_addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] alu;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] pc_ctr  = 32'h0000_0400;

  function automatic exp_t zero_e(input string tag);
    exp_t e;
    e.tag = tag; e.pc = 32'h0; e.ins = 32'h0; e.alu = 32'h0; e.rd = 32'h0; e.err = 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input exp_t e);
    chk({e.tag, ".pc"},  W_PC,       e.pc);
    chk({e.tag, ".ins"}, W_ins,      e.ins);
    chk({e.tag, ".alu"}, W_alu_res,  e.alu);
    chk({e.tag, ".rd"},  W_mem_read, e.rd);
    chk({e.tag, ".err"}, {31'h0, W_addr_err}, {31'h0, e.err});
  endtask

  // Present one instruction in M, predict the W-side result, then check it after the edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic fwd, input logic [31:0] wrw,
                       input logic [31:0] exp_rd, input logic exp_err, input string tag);
    exp_t e;
    pc_ctr      = pc_ctr + 32'd4;
    M_PC        = pc_ctr;
    M_ins       = {op, 26'h085_1234};
    M_alu_res   = addr;
    M_rt        = rt;
    fwd_rt_W    = fwd;
    W_reg_write = wrw;
    if (flush) begin
      e = zero_e(tag);
    end else if (!en) begin
      e = last_e;
      e.tag = tag;
    end else begin
      e.tag = tag; e.pc = M_PC; e.ins = M_ins; e.alu = addr; e.rd = exp_rd; e.err = exp_err;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = sb_q.pop_front();
      last_e = e;
      chk_w(e);
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; flush = 1'b0; fwd_rt_W = 1'b0;
    M_PC = 32'h1111_1110; M_ins = {OP_SW, 26'h085_1234}; M_alu_res = 32'h10;
    M_rt = 32'hFFFF_FFFF; W_reg_write = 32'h0;
    #2;
    chk_w(zero_e("reset0"));
    @(posedge clk);
    #1;
    chk_w(zero_e("reset1"));
    reset = 1'b1;
    last_e = zero_e("idle");

    // Word round trip
    issue(OP_SW, 32'h10, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 1'b0, "sw10");
    issue(OP_LW, 32'h10, 32'h0, 1'b0, 32'h0, 32'h1234_5678, 1'b0, "lw10");

    // Sign versus zero extension
    issue(OP_SW,  32'h20, 32'h80FF_7F01, 1'b0, 32'h0, 32'h0, 1'b0, "sw20");
    issue(OP_LB,  32'h20, 32'h0, 1'b0, 32'h0, 32'h0000_0001, 1'b0, "lb20");
    issue(OP_LB,  32'h22, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, "lb22");
    issue(OP_LB,  32'h23, 32'h0, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0, "lb23");
    issue(OP_LBU, 32'h22, 32'h0, 1'b0, 32'h0, 32'h0000_00FF, 1'b0, "lbu22");
    issue(OP_LH,  32'h22, 32'h0, 1'b0, 32'h0, 32'hFFFF_80FF, 1'b0, "lh22");
    issue(OP_LHU, 32'h22, 32'h0, 1'b0, 32'h0, 32'h0000_80FF, 1'b0, "lhu22");

    // Partial stores leave other lanes untouched
    issue(OP_SW, 32'h30, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, "sw30");
    issue(OP_SB, 32'h31, 32'h1234_56AB, 1'b0, 32'h0, 32'h0, 1'b0, "sb31");
    issue(OP_SH, 32'h32, 32'h9999_CDEF, 1'b0, 32'h0, 32'h0, 1'b0, "sh32");
    issue(OP_LW, 32'h30, 32'h0, 1'b0, 32'h0, 32'hCDEF_AB00, 1'b0, "lw30");

    // Store data forwarded from W
    issue(OP_SW, 32'h40, 32'h0000_0001, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, "sw40fwd");
    issue(OP_LW, 32'h40, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw40");

    // Alignment and range errors
    issue(OP_SW, 32'h42, 32'h5555_5555, 1'b0, 32'h0, 32'h0, 1'b1, "sw42err");
    issue(OP_SH, 32'h43, 32'h5555_5555, 1'b0, 32'h0, 32'h0, 1'b1, "sh43err");
    issue(OP_LW, 32'h40, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw40keep");
    issue(OP_LH, 32'h41, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, "lh41err");
    issue(OP_LW, 32'h42, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, "lw42err");
    issue(OP_LH, 32'h42, 32'h0, 1'b0, 32'h0, 32'hFFFF_DEAD, 1'b0, "lh42");
    issue(OP_LB, 32'h43, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFDE, 1'b0, "lb43");
    issue(OP_SW, 32'(4*DMW-4), 32'hA5A5_5A5A, 1'b0, 32'h0, 32'h0, 1'b0, "swlast");
    issue(OP_SW, 32'(4*DMW), 32'h0BAD_F00D, 1'b0, 32'h0, 32'h0, 1'b1, "swoob");
    issue(OP_LW, 32'(4*DMW), 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, "lwoob");
    issue(OP_LW, 32'(4*DMW-4), 32'h0, 1'b0, 32'h0, 32'hA5A5_5A5A, 1'b0, "lwlast");
    issue(6'b000000, 32'h41, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, "alu_nomem");

    // Flush suppresses the write and inserts a bubble, even when stalled
    issue(OP_SW, 32'h50, 32'h2222_2222, 1'b0, 32'h0, 32'h0, 1'b0, "sw50");
    flush = 1'b1;
    issue(OP_SW, 32'h50, 32'h1111_1111, 1'b0, 32'h0, 32'h0, 1'b0, "flush_sw");
    en = 1'b0;
    issue(OP_SW, 32'h50, 32'h3333_3333, 1'b0, 32'h0, 32'h0, 1'b0, "flush_stall");
    flush = 1'b0; en = 1'b1;
    issue(OP_LW, 32'h50, 32'h0, 1'b0, 32'h0, 32'h2222_2222, 1'b0, "lw50");

    // Stall holds W and suppresses the write
    issue(OP_LW, 32'h10, 32'h0, 1'b0, 32'h0, 32'h1234_5678, 1'b0, "lw10b");
    en = 1'b0;
    issue(OP_SW, 32'h10, 32'h9999_9999, 1'b0, 32'h0, 32'h0, 1'b0, "stall1");
    issue(OP_SW, 32'h10, 32'h9999_9999, 1'b0, 32'h0, 32'h0, 1'b0, "stall2");
    en = 1'b1;
    issue(OP_LW, 32'h10, 32'h0, 1'b0, 32'h0, 32'h1234_5678, 1'b0, "lw10c");

    // Asynchronous reset mid-stream; a store presented during reset is dropped
    issue(OP_LW, 32'h30, 32'h0, 1'b0, 32'h0, 32'hCDEF_AB00, 1'b0, "lw30b");
    M_ins = {OP_SW, 26'h085_1234}; M_alu_res = 32'h20; M_rt = 32'h0; fwd_rt_W = 1'b0;
    reset = 1'b0;
    #1;
    chk_w(zero_e("rst_async"));
    @(posedge clk);
    #1;
    chk_w(zero_e("rst_hold"));
    reset = 1'b1;
    last_e = zero_e("idle");
    issue(OP_LW, 32'h20, 32'h0, 1'b0, 32'h0, 32'h80FF_7F01, 1'b0, "lw20_after_rst");
    issue(OP_LW, 32'h30, 32'h0, 1'b0, 32'h0, 32'hCDEF_AB00, 1'b0, "lw30_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
